// File: rtl/gng_monitor.sv
// gng_monitor: block statistics over the Gaussian noise generator output.
// Each start enables the generator for N = 2^LOG2N cycles, gathers up to N
// samples and reports mean, mean square, min, max, count and a timeout flag.
`timescale 1ns/1ps
module gng_monitor #(
  parameter int LOG2N   = 10,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               ce_out,
  input  logic               valid_in,
  input  logic signed [15:0] data_in,
  output logic               done,
  output logic               err,
  output logic [16:0]        rx_count,
  output logic signed [15:0] mean,
  output logic [31:0]        msq,
  output logic signed [15:0] min_val,
  output logic signed [15:0] max_val
);

  localparam int DATA_W = 16;
  localparam int SQ_W   = 2 * DATA_W - 1;
  localparam int SUM_W  = DATA_W + LOG2N;
  localparam int SSQ_W  = SQ_W + LOG2N;
  localparam int CNT_W  = 17;
  localparam logic [CNT_W-1:0] N_SAMP   = CNT_W'(1) << LOG2N;
  localparam logic [CNT_W-1:0] N_M1     = N_SAMP - CNT_W'(1);
  localparam logic [15:0]      IDLE_LIM = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH, S_DONE} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] acc_cnt;
  logic [15:0]      idle_cnt;
  logic             flush_cnt;
  logic             err_flag;
  logic             clr;
  logic             accept;
  logic             blk_full;
  logic             timed_out;

  logic                     vld_p1;
  logic signed [DATA_W-1:0] sample_p1;
  logic [SQ_W-1:0]          sq_p1;

  logic signed [SUM_W-1:0]  sum_p2;
  logic [SSQ_W-1:0]         sumsq_p2;
  logic signed [DATA_W-1:0] min_p2;
  logic signed [DATA_W-1:0] max_p2;
  logic [CNT_W-1:0]         rx_p2;

  // Square of an s<16,11> sample; the magnitude never exceeds 2^30 so 31 bits hold it unsigned.
  function automatic logic [SQ_W-1:0] square(input logic signed [DATA_W-1:0] x);
    logic signed [2*DATA_W-1:0] p;
    p = x * x;
    return p[SQ_W-1:0];
  endfunction

  // Arithmetic shift truncates toward minus infinity; the quotient always fits 16 bits.
  function automatic logic signed [DATA_W-1:0] mean_of(input logic signed [SUM_W-1:0] s);
    return DATA_W'(s >>> LOG2N);
  endfunction

  function automatic logic [31:0] msq_of(input logic [SSQ_W-1:0] s);
    return 32'(s >> LOG2N);
  endfunction

  assign clr       = (state == S_IDLE) && start;
  assign accept    = valid_in && ((state == S_RUN) || (state == S_DRAIN)) && (acc_cnt < N_SAMP);
  assign blk_full  = (acc_cnt == N_SAMP) || (accept && (acc_cnt == N_M1));
  assign timed_out = (idle_cnt >= IDLE_LIM) && !accept;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (issue_cnt == N_M1) state_nxt = blk_full ? S_FLUSH : S_DRAIN;
      S_DRAIN: if (blk_full || timed_out) state_nxt = S_FLUSH;
      S_FLUSH: if (flush_cnt) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; FLUSH counts as busy so busy never dips mid-block
  always_comb begin
    ce_out = (state == S_RUN);
    busy   = (state != S_IDLE);
    done   = (state == S_DONE);
  end

  // Block control counters and the stage-1 valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
      acc_cnt   <= '0;
      idle_cnt  <= '0;
      flush_cnt <= 1'b0;
      err_flag  <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      if (clr) begin
        issue_cnt <= '0;
        acc_cnt   <= '0;
        idle_cnt  <= '0;
        err_flag  <= 1'b0;
      end else begin
        if (state == S_RUN) issue_cnt <= issue_cnt + CNT_W'(1);
        if (accept) acc_cnt <= acc_cnt + CNT_W'(1);
        if (accept) idle_cnt <= '0;
        else if (idle_cnt < IDLE_LIM) idle_cnt <= idle_cnt + 16'd1;
        if ((state == S_DRAIN) && !blk_full && timed_out) err_flag <= 1'b1;
      end
      flush_cnt <= (state == S_FLUSH) ? ~flush_cnt : 1'b0;
      vld_p1    <= accept;
    end
  end

  // ---- stage 1: register sample and its square ----
  always_ff @(posedge clk) begin
    sample_p1 <= data_in;
    sq_p1     <= square(data_in);
  end

  // ---- stage 2: accumulate sum, sum of squares, extremes and count ----
  always_ff @(posedge clk) begin
    if (clr) begin
      sum_p2   <= '0;
      sumsq_p2 <= '0;
      min_p2   <= 16'sh7FFF;
      max_p2   <= 16'sh8000;
      rx_p2    <= '0;
    end else if (vld_p1) begin
      sum_p2   <= sum_p2 + SUM_W'(sample_p1);
      sumsq_p2 <= sumsq_p2 + SSQ_W'(sq_p1);
      if (sample_p1 < min_p2) min_p2 <= sample_p1;
      if (sample_p1 > max_p2) max_p2 <= sample_p1;
      rx_p2    <= rx_p2 + CNT_W'(1);
    end
  end

  // ---- result capture: loaded as the state enters DONE, held until the next DONE ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err      <= 1'b0;
      rx_count <= '0;
      mean     <= '0;
      msq      <= '0;
      min_val  <= '0;
      max_val  <= '0;
    end else if ((state == S_FLUSH) && flush_cnt) begin
      err      <= err_flag;
      rx_count <= rx_p2;
      mean     <= mean_of(sum_p2);
      msq      <= msq_of(sumsq_p2);
      min_val  <= min_p2;
      max_val  <= max_p2;
    end
  end

endmodule
